// File: rtl/reg_bank_32_if.sv
// Write/clear handshake and flat register readout bus for reg_bank_32.
interface reg_bank_32_if #(
  parameter int DW = 32
);
  logic              Wr_Valid;
  logic              Wr_Ready;
  logic [4:0]        Wr_Addr;
  logic [DW-1:0]     Wr_Data;
  logic              Clr_Req;
  logic              Busy;
  logic [32*DW-1:0]  Reg_Flat;

  modport master (
    output Wr_Valid, Wr_Addr, Wr_Data, Clr_Req,
    input  Wr_Ready, Busy, Reg_Flat
  );

  modport slave (
    input  Wr_Valid, Wr_Addr, Wr_Data, Clr_Req,
    output Wr_Ready, Busy, Reg_Flat
  );
endinterface

// File: rtl/reg_bank_32.sv
// 32 x DW register storage with a handshaked write port and a sequential bulk-clear engine.
// Optional macro REG0_HARDWIRE_EN: entry 0 is constant zero and has no storage.
module reg_bank_32 #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  reg_bank_32_if.slave  bus
);

`ifdef REG0_HARDWIRE_EN
  localparam int unsigned LO = 1;
`else
  localparam int unsigned LO = 0;
`endif

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [DW-1:0]     mem_q [LO:31];
  logic              wr_acc;
  logic [32*DW-1:0]  flat;

  assign bus.Busy     = (state_q == CLEAR);
  assign bus.Wr_Ready = (state_q == IDLE);
  assign wr_acc       = bus.Wr_Valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.Clr_Req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        // Exit decided on the last index so the counter never wraps.
        if (idx_q == 5'd31) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = LO; i < 32; i++) begin
      if (rst) begin
        mem_q[i] <= '0;
      end else if (state_q == CLEAR && idx_q == i[4:0]) begin
        mem_q[i] <= '0;
      end else if (wr_acc && bus.Wr_Addr == i[4:0]) begin
        mem_q[i] <= bus.Wr_Data;
      end
    end
  end

  always_comb begin
    flat = '0;
    for (int unsigned i = LO; i < 32; i++) begin
      flat[i*DW +: DW] = mem_q[i];
    end
  end

  assign bus.Reg_Flat = flat;

endmodule

// File: tb/tb_reg_bank_32.sv
// Directed and randomized checks of reg_bank_32 against an array-based reference model.
module tb_reg_bank_32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [DW-1:0] m [32];
  int            clr_left;
  int            busy_cnt;

  reg_bank_32_if #(.DW(DW)) bif ();

  reg_bank_32 #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

`ifdef REG0_HARDWIRE_EN
  localparam bit HW0 = 1'b1;
`else
  localparam bit HW0 = 1'b0;
`endif

  function automatic logic [32*DW-1:0] model_flat();
    logic [32*DW-1:0] f;
    for (int i = 0; i < 32; i++) f[i*DW +: DW] = m[i];
    return f;
  endfunction

  task automatic check(input string tag, input logic [32*DW-1:0] obs, input logic [32*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic step(input string tag);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m[i] = '0;
      clr_left = 0;
    end else if (clr_left > 0) begin
      m[32 - clr_left] = '0;
      clr_left--;
    end else begin
      if (bif.Wr_Valid && !(HW0 && bif.Wr_Addr == 5'd0)) m[bif.Wr_Addr] = bif.Wr_Data;
      if (bif.Clr_Req) clr_left = 32;
    end
    #1;
    check({tag, ".flat"}, bif.Reg_Flat, model_flat());
    check({tag, ".busy"}, {{(32*DW-1){1'b0}}, bif.Busy}, {{(32*DW-1){1'b0}}, (clr_left > 0)});
    check({tag, ".ready"}, {{(32*DW-1){1'b0}}, bif.Wr_Ready}, {{(32*DW-1){1'b0}}, (clr_left == 0)});
  endtask

  task automatic idle_inputs();
    bif.Wr_Valid = 1'b0;
    bif.Wr_Addr  = '0;
    bif.Wr_Data  = '0;
    bif.Clr_Req  = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [DW-1:0] d, input string tag);
    bif.Wr_Valid = 1'b1;
    bif.Wr_Addr  = a;
    bif.Wr_Data  = d;
    step(tag);
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m[i] = 'x;
    clr_left = 0;
    idle_inputs();

    // Reset state
    rst = 1'b1;
    step("reset");
    rst = 1'b0;
    check("reset_flat_zero", bif.Reg_Flat, '0);
    step("post_reset");

    // Single write
    do_write(5'd5, 32'hDEADBEEF, "wr5");
    check("wr5_entry", {{(31*DW){1'b0}}, bif.Reg_Flat[5*DW +: DW]}, {{(31*DW){1'b0}}, 32'hDEADBEEF});

    // Fill with index+1, then bulk clear with writes offered while busy
    for (int i = 0; i < 32; i++) do_write(5'(i), DW'(i + 1), "fill");
    bif.Clr_Req = 1'b1;
    step("clr_pulse");
    bif.Clr_Req = 1'b0;
    busy_cnt = bif.Busy ? 1 : 0;
    for (int k = 0; k < 40 && bif.Busy; k++) begin
      bif.Wr_Valid = 1'b1;
      bif.Wr_Addr  = 5'($urandom_range(0, 31));
      bif.Wr_Data  = $urandom;
      step("clr_run");
      bif.Wr_Valid = 1'b0;
      if (bif.Busy) busy_cnt++;
    end
    check("busy_cycles", DW'(busy_cnt), DW'(32));
    check("clr_all_zero", bif.Reg_Flat, '0);

    // Write and clear request in the same idle cycle
    step("idle");
    bif.Wr_Valid = 1'b1;
    bif.Wr_Addr  = 5'd7;
    bif.Wr_Data  = 32'h1234;
    bif.Clr_Req  = 1'b1;
    step("wr_clr_same");
    idle_inputs();
    check("e7_written", {{(31*DW){1'b0}}, bif.Reg_Flat[7*DW +: DW]}, {{(31*DW){1'b0}}, 32'h1234});
    for (int k = 0; k < 34; k++) step("wr_clr_run");
    check("wr_clr_final_zero", bif.Reg_Flat, '0);

    // Reset in the middle of a clear
    for (int i = 0; i < 32; i++) do_write(5'(i), $urandom, "refill");
    bif.Clr_Req = 1'b1;
    step("clr2");
    bif.Clr_Req = 1'b0;
    for (int k = 0; k < 9; k++) step("clr2_run");
    rst = 1'b1;
    step("rst_mid_clear");
    rst = 1'b0;
    check("rst_mid_zero", bif.Reg_Flat, '0);
    step("after_rst");

    // Entry 0 write
    do_write(5'd0, 32'hFFFFFFFF, "wr0");
    check("entry0", {{(31*DW){1'b0}}, bif.Reg_Flat[DW-1:0]},
          {{(31*DW){1'b0}}, (HW0 ? 32'h0 : 32'hFFFFFFFF)});

    // Clear request held high across a clear exit
    for (int i = 0; i < 32; i++) do_write(5'(i), $urandom, "refill2");
    bif.Clr_Req = 1'b1;
    for (int k = 0; k < 70; k++) begin
      bif.Wr_Valid = 1'b1;
      bif.Wr_Addr  = 5'($urandom_range(0, 31));
      bif.Wr_Data  = $urandom;
      step("clr_held");
    end
    idle_inputs();
    for (int k = 0; k < 40; k++) step("drain");

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      rst          = ($urandom_range(0, 99) == 0);
      bif.Wr_Valid = $urandom_range(0, 1) == 1;
      bif.Wr_Addr  = 5'($urandom_range(0, 31));
      bif.Wr_Data  = $urandom;
      bif.Clr_Req  = ($urandom_range(0, 29) == 0);
      step("random");
    end
    rst = 1'b0;
    idle_inputs();
    step("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
